// File: rtl/encoder_scan_pkg.sv
// Shared types and helpers for the sequential scan encoder.
package encoder_scan_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OUT  = 1'b1
  } state_t;

  // popcount takes a fixed maximum width; callers zero-extend, so N may not exceed it.
  localparam int unsigned POP_MAX_W = 256;
  localparam int unsigned ZERO_IDX  = 0;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/find_first_set.sv
// Combinational find-first-set: index of the lowest (or, with MSB_FIRST, highest) set bit.
module find_first_set
  import encoder_scan_pkg::*;
#(
  parameter  int N         = 8,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int IDXW      = $clog2(N)
) (
  input  logic [N-1:0]    vec,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  int unsigned j;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx   = IDXW'(ZERO_IDX);
    found = 1'b0;
    j     = 0;
    // The last hit in the walk wins, so the walk runs away from the preferred end.
    for (int i = 0; i < N; i++) begin
      j = MSB_FIRST ? i : N - 1 - i;
      if (vec[j]) begin
        idx   = IDXW'(j);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_scan_seq.sv
// Sequential scan encoder: emits the index of every set request bit, one per handshake.
// Build option: define ENC_SCAN_MSB_FIRST_EN to scan from the highest set bit downward.
module encoder_scan_seq
  import encoder_scan_pkg::*;
#(
  parameter  int N    = 8,
  localparam int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [N-1:0]    req_vec,
  output logic            idx_valid,
  input  logic            idx_ready,
  output logic [IDXW-1:0] idx,
  output logic            idx_last,
  output logic            idx_zero,
  output logic [IDXW:0]   pop_cnt
);

`ifdef ENC_SCAN_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  state_t          state, state_next;
  logic [N-1:0]    mask, mask_next;
  logic            capture, load;
  logic [IDXW-1:0] ffs_idx;
  logic            ffs_found;
  int unsigned     next_cnt;

  assign req_ready = en && (state == S_IDLE);
  assign idx_valid = (state == S_OUT);

  always_comb begin
    state_next = state;
    mask_next  = mask;
    capture    = 1'b0;
    load       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (en && req_valid) begin
          capture    = 1'b1;
          load       = 1'b1;
          mask_next  = req_vec;
          state_next = S_OUT;
        end
      end
      S_OUT: begin
        // Dropping en wins over a concurrent handshake and discards the rest of the scan.
        if (!en) begin
          mask_next  = '0;
          state_next = S_IDLE;
        end else if (idx_ready) begin
          if (idx_last) begin
            mask_next  = '0;
            state_next = S_IDLE;
          end else begin
            mask_next = mask & ~(N'(1) << idx);
            load      = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  find_first_set #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_ffs (
    .vec   (mask_next),
    .idx   (ffs_idx),
    .found (ffs_found)
  );

  assign next_cnt = popcount(POP_MAX_W'(mask_next));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mask     <= '0;
      idx      <= '0;
      idx_last <= 1'b0;
      idx_zero <= 1'b0;
      pop_cnt  <= '0;
    end else begin
      state <= state_next;
      mask  <= mask_next;
      if (load) begin
        // An empty vector still yields one terminal beat at the zero index.
        idx      <= ffs_found ? ffs_idx : IDXW'(ZERO_IDX);
        idx_last <= !ffs_found || (next_cnt == 1);
      end
      if (capture) begin
        idx_zero <= !ffs_found;
        pop_cnt  <= (IDXW+1)'(next_cnt);
      end
    end
  end

endmodule

// File: tb/tb_encoder_scan_seq.sv
// Directed bench for encoder_scan_seq with a scoreboard of expected index beats.
module tb_encoder_scan_seq;

  localparam int N    = 8;
  localparam int IDXW = $clog2(N);

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic            last;
    logic            zero;
    logic [IDXW:0]   pop;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n, en, req_valid, idx_ready;
  logic [N-1:0]    req_vec;
  logic            req_ready, idx_valid, idx_last, idx_zero;
  logic [IDXW-1:0] idx;
  logic [IDXW:0]   pop_cnt;

  beat_t           sb[$];
  logic [IDXW-1:0] last_exp_idx;
  int              n_checks = 0;
  int              n_fail   = 0;

  encoder_scan_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_vec   (req_vec),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .idx       (idx),
    .idx_last  (idx_last),
    .idx_zero  (idx_zero),
    .pop_cnt   (pop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected beat sequence for one captured vector.
  task automatic push_vec(input logic [N-1:0] v);
    int cnt, k, b;
    cnt = $countones(v);
    k   = 0;
    if (cnt == 0) begin
      sb.push_back('{idx: '0, last: 1'b1, zero: 1'b1, pop: '0});
      last_exp_idx = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
`ifdef ENC_SCAN_MSB_FIRST_EN
        b = N - 1 - i;
`else
        b = i;
`endif
        if (v[b]) begin
          k++;
          sb.push_back('{idx: IDXW'(b), last: (k == cnt), zero: 1'b0, pop: (IDXW+1)'(cnt)});
          last_exp_idx = IDXW'(b);
        end
      end
    end
  endtask

  // One clock: compare any visible beat at the falling edge, then step past the rising edge.
  task automatic tick();
    beat_t e;
    @(negedge clk);
    if (idx_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 32'(idx_valid), 32'd0);
      end else begin
        e = sb[0];
        check("beat_idx",  32'(idx),      32'(e.idx));
        check("beat_last", 32'(idx_last), 32'(e.last));
        check("beat_zero", 32'(idx_zero), 32'(e.zero));
        check("beat_pop",  32'(pop_cnt),  32'(e.pop));
        if (idx_ready && en) void'(sb.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] v);
    req_valid = 1'b1;
    req_vec   = v;
    push_vec(v);
    check("send_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("latency_valid", 32'(idx_valid), 32'd1);
  endtask

  task automatic drain(input int budget, input bit stall);
    for (int i = 0; i < budget && sb.size() > 0; i++) begin
      idx_ready = stall ? (i % 2 == 0) : 1'b1;
      tick();
    end
    check("drain_done", 32'(sb.size()), 32'd0);
    idx_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    req_valid = 1'b1;
    req_vec   = 8'h55;
    idx_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid",  32'(idx_valid), 32'd0);
    check("rst_ready",  32'(req_ready), 32'd0);
    check("rst_pop",    32'(pop_cnt),   32'd0);
    check("rst_idx",    32'(idx),       32'd0);
    check("rst_last",   32'(idx_last),  32'd0);
    check("rst_zero",   32'(idx_zero),  32'd0);

    rst_n     = 1'b1;
    en        = 1'b1;
    req_valid = 1'b0;
    idx_ready = 1'b1;
    #1;
    check("idle_ready", 32'(req_ready), 32'd1);

    // One-hot
    send(8'b0000_1000);
    drain(10, 1'b0);
    check("onehot_idle", 32'(idx_valid), 32'd0);

    // Multi-hot with backpressure
    send(8'b1010_0110);
    drain(40, 1'b1);
    check("multi_idle",     32'(idx_valid), 32'd0);
    check("multi_pop_hold", 32'(pop_cnt),   32'd4);
    check("multi_idx_hold", 32'(idx),       32'(last_exp_idx));
    check("multi_last_hold", 32'(idx_last), 32'd1);

    // All-zero vector
    send(8'h00);
    drain(10, 1'b0);
    check("zero_idle", 32'(idx_valid), 32'd0);
    check("zero_pop",  32'(pop_cnt),   32'd0);
    check("zero_flag", 32'(idx_zero),  32'd1);

    // Abort after three accepted beats
    send(8'hFF);
    repeat (3) tick();
    check("abort_remaining", 32'(sb.size()), 32'd5);
    check("abort_pre_valid", 32'(idx_valid), 32'd1);
    en = 1'b0;
    tick();
    check("abort_valid",    32'(idx_valid), 32'd0);
    check("abort_ready",    32'(req_ready), 32'd0);
    check("abort_idx_hold", 32'(idx),       32'(sb[0].idx));
    check("abort_last",     32'(idx_last),  32'd0);
    sb.delete();
    req_valid = 1'b1;
    req_vec   = 8'h80;
    tick();
    check("en_low_no_capture", 32'(idx_valid), 32'd0);
    en = 1'b1;
    #1;
    send(8'h80);
    drain(10, 1'b0);
    check("post_abort_idle", 32'(idx_valid), 32'd0);

    // Back-to-back with req_valid held high
    req_valid = 1'b1;
    req_vec   = 8'h01;
    push_vec(8'h01);
    push_vec(8'h02);
    tick();
    req_vec = 8'h02;
    check("b2b_first_valid", 32'(idx_valid), 32'd1);
    check("b2b_busy_ready",  32'(req_ready), 32'd0);
    tick();
    check("b2b_gap_valid", 32'(idx_valid), 32'd0);
    check("b2b_gap_ready", 32'(req_ready), 32'd1);
    check("b2b_gap_queue", 32'(sb.size()), 32'd1);
    tick();
    req_valid = 1'b0;
    check("b2b_second_valid", 32'(idx_valid), 32'd1);
    drain(10, 1'b0);
    check("b2b_idle", 32'(idx_valid), 32'd0);
    tick();
    check("final_no_beat", 32'(idx_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
